// File: rtl/regfile_sb_mp.sv
// Multi-read-port register file with write-to-read bypass and a pending-write
// scoreboard (busy bit per register plus a running count of pending registers).
module regfile_sb_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
  output logic [NUM_RD*DATA_W-1:0] rdData,
  output logic [NUM_RD-1:0]        rdBusy,
  input  logic                     wrEn,
  input  logic [ADDR_W-1:0]        wrAddr,
  input  logic [DATA_W-1:0]        wrData,
  input  logic                     issueEn,
  input  logic [ADDR_W-1:0]        issueAddr,
  input  logic                     flush,
  output logic [ADDR_W:0]          pendCnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pendNext;
  logic              wrValid;
  logic              issueValid;
  logic              cntInc;
  logic              cntDec;

  // Register 0 neither accepts data nor becomes pending when hard-wired to zero.
  assign wrValid    = wrEn && !((ZERO_REG != 0) && (wrAddr == '0));
  assign issueValid = issueEn && !((ZERO_REG != 0) && (issueAddr == '0));

  // Count moves only on real transitions; a same-register issue+writeback keeps it pending.
  assign cntInc = issueValid && !pend[issueAddr];
  assign cntDec = wrValid && pend[wrAddr] && !(issueValid && (issueAddr == wrAddr));

  always_comb begin
    pendNext = pend;
    if (wrValid) pendNext[wrAddr] = 1'b0;
    if (issueValid) pendNext[issueAddr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
    end else if (wrValid) begin
      regs[wrAddr] <= wrData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      pendCnt <= '0;
    end else if (flush) begin
      pend    <= '0;
      pendCnt <= '0;
    end else begin
      pend    <= pendNext;
      pendCnt <= pendCnt + CNT_W'(cntInc) - CNT_W'(cntDec);
    end
  end

  // Read ports; forwarding is suppressed during reset so outputs read zero.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              hit;
    logic              reissue;
    rdData  = '0;
    rdBusy  = '0;
    a       = '0;
    hit     = 1'b0;
    reissue = 1'b0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      a       = rdAddr[k*ADDR_W +: ADDR_W];
      hit     = (BYPASS != 0) && rst_n && wrEn && (wrAddr == a);
      reissue = issueEn && (issueAddr == a);
      if ((ZERO_REG != 0) && (a == '0)) begin
        rdData[k*DATA_W +: DATA_W] = '0;
      end else if (hit) begin
        rdData[k*DATA_W +: DATA_W] = wrData;
      end else begin
        rdData[k*DATA_W +: DATA_W] = regs[a];
      end
      rdBusy[k] = pend[a] && !(hit && !reissue);
    end
  end

endmodule

// File: tb/tb_regfile_sb_mp.sv
// Bench for regfile_sb_mp: a bypassing and a non-bypassing instance share
// stimulus and are checked every cycle against an array-based reference model.
module tb_regfile_sb_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR*AW-1:0]  rdAddr;
  logic              wrEn;
  logic [AW-1:0]     wrAddr;
  logic [DW-1:0]     wrData;
  logic              issueEn;
  logic [AW-1:0]     issueAddr;
  logic              flush;

  logic [NR*DW-1:0]  dutData, nbData;
  logic [NR-1:0]     dutBusy, nbBusy;
  logic [AW:0]       dutCnt, nbCnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_sb_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rdAddr(rdAddr), .rdData(dutData), .rdBusy(dutBusy),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .issueEn(issueEn),
    .issueAddr(issueAddr), .flush(flush), .pendCnt(dutCnt)
  );

  regfile_sb_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rdAddr(rdAddr), .rdData(nbData), .rdBusy(nbBusy),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .issueEn(issueEn),
    .issueAddr(issueAddr), .flush(flush), .pendCnt(nbCnt)
  );

  // Reference model: architectural values and the set of pending registers.
  logic [DW-1:0] mRegs [32];
  logic [31:0]   mPend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mRegs[i] = '0;
      mPend = '0;
    end else begin
      if (wrEn && wrAddr != 0) mRegs[wrAddr] = wrData;
      if (flush) mPend = '0;
      else begin
        if (wrEn) mPend[wrAddr] = 1'b0;
        if (issueEn && issueAddr != 0) mPend[issueAddr] = 1'b1;
      end
    end
  end

  function automatic logic [DW-1:0] expRd(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && rst_n && wrEn && wrAddr == a) return wrData;
    return mRegs[a];
  endfunction

  function automatic logic expBusy(input logic [AW-1:0] a, input bit byp);
    if (byp && rst_n && wrEn && wrAddr == a && !(issueEn && issueAddr == a)) return 1'b0;
    return mPend[a];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < int'(NR); k++) begin
      logic [AW-1:0] a;
      a = rdAddr[k*AW +: AW];
      chk($sformatf("byp_data%0d", k), 64'(dutData[k*DW +: DW]), 64'(expRd(a, 1'b1)));
      chk($sformatf("byp_busy%0d", k), 64'(dutBusy[k]), 64'(expBusy(a, 1'b1)));
      chk($sformatf("nb_data%0d", k), 64'(nbData[k*DW +: DW]), 64'(expRd(a, 1'b0)));
      chk($sformatf("nb_busy%0d", k), 64'(nbBusy[k]), 64'(expBusy(a, 1'b0)));
    end
    chk("byp_cnt", 64'(dutCnt), 64'($countones(mPend)));
    chk("nb_cnt", 64'(nbCnt), 64'($countones(mPend)));
  end

  task automatic idle();
    wrEn = 1'b0; wrAddr = '0; wrData = '0;
    issueEn = 1'b0; issueAddr = '0; flush = 1'b0;
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic setRd(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    rdAddr = {a1, a0};
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rdAddr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    setRd(5'd5, 5'd0);
    @(negedge clk);
    chk("lit_rst_data", 64'(dutData), 64'h0);
    chk("lit_rst_busy", 64'(dutBusy), 64'h0);
    chk("lit_rst_cnt", 64'(dutCnt), 64'h0);

    nextCyc(); wrEn = 1'b1; wrAddr = 5'd6; wrData = 32'h12345678; setRd(5'd5, 5'd6);
    @(negedge clk);
    chk("lit_byp_same", 64'(dutData[31:0]), 64'h12345678);
    chk("lit_nobyp_old", 64'(nbData[31:0]), 64'h0);
    nextCyc();
    @(negedge clk);
    chk("lit_nobyp_next", 64'(nbData[31:0]), 64'h12345678);

    nextCyc(); wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'hFFFFFFFF;
    issueEn = 1'b1; issueAddr = 5'd0; setRd(5'd0, 5'd0);
    @(negedge clk);
    chk("lit_z_data_same", 64'(dutData), 64'h0);
    nextCyc();
    @(negedge clk);
    chk("lit_z_data", 64'(dutData), 64'h0);
    chk("lit_z_busy", 64'(dutBusy), 64'h0);
    chk("lit_z_cnt", 64'(dutCnt), 64'h0);

    nextCyc(); issueEn = 1'b1; issueAddr = 5'd3; setRd(5'd3, 5'd3);
    @(negedge clk);
    chk("lit_iss_busy_same", 64'(dutBusy), 64'h0);
    nextCyc();
    @(negedge clk);
    chk("lit_iss_busy", 64'(dutBusy), 64'h3);
    chk("lit_iss_cnt", 64'(dutCnt), 64'h1);
    nextCyc(); wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'hA5;
    @(negedge clk);
    chk("lit_wb_busy_byp", 64'(dutBusy), 64'h0);
    chk("lit_wb_busy_nobyp", 64'(nbBusy), 64'h3);
    chk("lit_wb_data", 64'(dutData[31:0]), 64'hA5);
    chk("lit_wb_cnt_same", 64'(dutCnt), 64'h1);
    nextCyc();
    @(negedge clk);
    chk("lit_wb_cnt", 64'(dutCnt), 64'h0);

    nextCyc(); issueEn = 1'b1; issueAddr = 5'd9;
    nextCyc(); issueEn = 1'b1; issueAddr = 5'd7; wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'h55;
    nextCyc(); setRd(5'd9, 5'd7);
    @(negedge clk);
    chk("lit_sim_data", 64'(dutData[31:0]), 64'h55);
    chk("lit_sim_busy", 64'(dutBusy), 64'h3);
    chk("lit_sim_cnt", 64'(dutCnt), 64'h2);
    nextCyc(); issueEn = 1'b1; issueAddr = 5'd8; wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'h99;
    nextCyc(); setRd(5'd8, 5'd9);
    @(negedge clk);
    chk("lit_net0_cnt", 64'(dutCnt), 64'h2);
    chk("lit_net0_busy", 64'(dutBusy), 64'h2);

    nextCyc(); issueEn = 1'b1; issueAddr = 5'd1;
    nextCyc(); issueEn = 1'b1; issueAddr = 5'd2;
    nextCyc(); issueEn = 1'b1; issueAddr = 5'd4;
    nextCyc();
    @(negedge clk);
    chk("lit_pre_flush_cnt", 64'(dutCnt), 64'h5);
    nextCyc(); flush = 1'b1; issueEn = 1'b1; issueAddr = 5'd5;
    nextCyc(); setRd(5'd5, 5'd6);
    @(negedge clk);
    chk("lit_flush_cnt", 64'(dutCnt), 64'h0);
    chk("lit_flush_busy", 64'(dutBusy), 64'h0);
    chk("lit_flush_data", 64'(dutData[31:0]), 64'h12345678);

    nextCyc(); issueEn = 1'b1; issueAddr = 5'd10;
    nextCyc(); issueEn = 1'b1; issueAddr = 5'd10;
    nextCyc(); wrEn = 1'b1; wrAddr = 5'd11; wrData = 32'h11;
    nextCyc(); setRd(5'd10, 5'd6);
    @(negedge clk);
    chk("lit_reissue_cnt", 64'(dutCnt), 64'h1);
    chk("lit_reissue_busy", 64'(dutBusy), 64'h2);

    nextCyc();
    #1 rst_n = 1'b0;
    wrEn = 1'b1; wrAddr = 5'd6; wrData = 32'hDEAD; issueEn = 1'b1; issueAddr = 5'd12;
    #1;
    chk("lit_arst_data", 64'(dutData), 64'h0);
    chk("lit_arst_busy", 64'(dutBusy), 64'h0);
    chk("lit_arst_cnt", 64'(dutCnt), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(); setRd(5'd12, 5'd6);
    @(negedge clk);
    chk("lit_arst_discard", 64'(dutData), 64'h0);
    chk("lit_arst_discard_busy", 64'(dutBusy), 64'h0);

    for (int n = 0; n < 80; n++) begin
      nextCyc();
      wrEn      = 1'($urandom_range(0, 1));
      wrAddr    = 5'($urandom_range(0, 15));
      wrData    = $urandom;
      issueEn   = 1'($urandom_range(0, 1));
      issueAddr = 5'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 15) == 0);
      setRd(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    nextCyc();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
